// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               register offsets, STATUS bit positions, FSM state encoding
//               and the divisor sanitising helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_tx_mmio_pkg;

    // Register offsets within the 4-word window
    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_div    = 2'd2;

    // STATUS bit positions
    localparam int c_st_full    = 0;
    localparam int c_st_empty   = 1;
    localparam int c_st_busy    = 2;
    localparam int c_st_ovf     = 3;
    localparam int c_st_cnt_lsb = 4;

    // Transmit FSM state encoding
    typedef enum logic [1:0] {
        c_st_idle  = 2'd0,
        c_st_start = 2'd1,
        c_st_data  = 2'd2,
        c_st_stop  = 2'd3
    } tx_state_t;

    // A zero bit period is meaningless; clamp it to one cycle
    function automatic logic [15:0] div_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word fall-through output.
//               A pop on the same edge as a push to a full FIFO frees the
//               slot, so the push is accepted.
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array: only accepted pushes write, contents need no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter. Bus decode, DIV and
//               overflow registers, 16-entry byte FIFO, bit-timer FSM and
//               the tri-state read driver onto the shared data bus.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h3FFFFFF0,
    parameter int          FIFO_AW   = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [29:0] memaddr,
    inout  wire  [31:0] memdata,
    output logic        txd,
    output logic        tx_idle
);

    logic              w_sel;
    logic [1:0]        w_reg;
    logic              r_we_tog;
    logic              r_we_ack;
    logic [15:0]       r_wdata;
    logic              w_store;
    logic              w_push;
    logic              w_pop;
    logic [15:0]       r_div;
    logic              r_ovf;
    logic [31:0]       w_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FIFO_AW:0]  w_fifo_cnt;
    logic [7:0]        w_fifo_dout;
    tx_state_t         r_state;
    logic [7:0]        r_sh;
    logic [15:0]       r_bitcnt;
    logic [2:0]        r_bitidx;
    logic              r_txd;
    logic              w_bit_end;
    logic [15:0]       w_reload;

    assign w_sel = (memaddr[29:2] == BASE_ADDR[29:2]);
    assign w_reg = memaddr[1:0];

    // mem_we pulses in the low phase; a toggle that differs from its
    // clk-side acknowledge marks exactly one store in the ending cycle
    assign w_store = (r_we_tog ^ r_we_ack) && w_sel && !mem_re;
    assign w_push  = w_store && (w_reg == c_reg_data);

    assign w_bit_end = (r_bitcnt == 16'd0);
    assign w_reload  = r_div - 16'd1;
    assign w_pop     = !w_fifo_empty &&
                       ((r_state == c_st_idle) || ((r_state == c_st_stop) && w_bit_end));

    assign txd     = r_txd;
    assign tx_idle = w_fifo_empty && (r_state == c_st_idle);
    assign memdata = (mem_re && w_sel) ? w_rdata : 32'bz;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (r_wdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    // Each write strobe flips the toggle and captures the bus data
    always_ff @(posedge mem_we or posedge rst) begin
        if (rst) begin
            r_we_tog <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_we_tog <= ~r_we_tog;
            r_wdata  <= memdata[15:0];
        end
    end

    // Commit register writes and track overflow at the edge ending the cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_ack <= 1'b0;
            r_div    <= DIV_RESET;
            r_ovf    <= 1'b0;
        end else begin
            r_we_ack <= r_we_tog;
            if (w_push && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_store && (w_reg == c_reg_status) && r_wdata[c_st_ovf]) begin
                r_ovf <= 1'b0;
            end
            if (w_store && (w_reg == c_reg_div)) begin
                r_div <= div_sanitize(r_wdata);
            end
        end
    end

    // Serialise FIFO bytes: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_sh     <= '0;
            r_bitcnt <= '0;
            r_bitidx <= '0;
            r_txd    <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        r_sh     <= w_fifo_dout;
                        r_txd    <= 1'b0;
                        r_bitcnt <= w_reload;
                        r_state  <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_txd    <= r_sh[0];
                        r_bitcnt <= w_reload;
                        r_bitidx <= '0;
                        r_state  <= c_st_data;
                    end else begin
                        r_bitcnt <= r_bitcnt - 16'd1;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_bitcnt <= w_reload;
                        if (r_bitidx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_txd    <= r_sh[1];
                            r_sh     <= {1'b0, r_sh[7:1]};
                            r_bitidx <= r_bitidx + 3'd1;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt - 16'd1;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_sh     <= w_fifo_dout;
                            r_txd    <= 1'b0;
                            r_bitcnt <= w_reload;
                            r_state  <= c_st_start;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // Read data for the addressed register, valid within the request cycle
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            c_reg_status: begin
                w_rdata[c_st_full]                    = w_fifo_full;
                w_rdata[c_st_empty]                   = w_fifo_empty;
                w_rdata[c_st_busy]                    = (r_state != c_st_idle);
                w_rdata[c_st_ovf]                     = r_ovf;
                w_rdata[c_st_cnt_lsb +: FIFO_AW + 1]  = w_fifo_cnt;
            end
            c_reg_div: begin
                w_rdata[15:0] = r_div;
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio. A frame-level model
//               (byte queue plus a list of pending line bits) predicts txd,
//               tx_idle and register reads every cycle; directed scenarios
//               pin the model with hand-computed values, then random bus
//               traffic exercises it further.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam logic [29:0] c_base = 30'h3FFFFFF0;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic [29:0] memaddr = '0;
    wire  [31:0] memdata;
    logic        txd;
    logic        tx_idle;
    logic        tb_oe  = 1'b0;
    logic [31:0] tb_val = '0;
    bit          cmp_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Current bus cycle as seen by the model at the edge ending it
    bit          cyc_store = 1'b0;
    bit          cyc_sel   = 1'b0;
    logic [1:0]  cyc_reg   = '0;
    logic [31:0] cyc_data  = '0;

    assign memdata = tb_oe ? tb_val : 32'bz;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR (c_base),
        .FIFO_AW   (4),
        .DIV_RESET (16'd868)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_re  (mem_re),
        .mem_we  (mem_we),
        .memaddr (memaddr),
        .memdata (memdata),
        .txd     (txd),
        .tx_idle (tx_idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit         m_bits[$];
    bit         m_active;
    bit         m_cur;
    int         m_rem;
    int         m_div;
    bit         m_ovf;
    logic [7:0] m_b;

    function automatic logic [31:0] m_read(input logic [1:0] r);
        logic [31:0] v;
        logic [4:0]  cnt;
        v   = '0;
        cnt = 5'(m_q.size());
        if (r == 2'd1) v = {23'd0, cnt, m_ovf, m_active, (cnt == 5'd0), (cnt == 5'd16)};
        else if (r == 2'd2) v = 32'(m_div);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_bits.delete();
            m_active = 1'b0;
            m_cur    = 1'b1;
            m_rem    = 0;
            m_div    = 868;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (m_bits.size() > 0) begin
                        m_cur = m_bits.pop_front();
                        m_rem = m_div;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end
            if (!m_active && m_q.size() > 0) begin
                m_b = m_q.pop_front();
                m_bits.delete();
                for (int i = 0; i < 8; i++) m_bits.push_back(m_b[i]);
                m_bits.push_back(1'b1);
                m_cur    = 1'b0;
                m_rem    = m_div;
                m_active = 1'b1;
            end
            if (cyc_store && cyc_sel) begin
                case (cyc_reg)
                    2'd0: if (m_q.size() < 16) m_q.push_back(cyc_data[7:0]); else m_ovf = 1'b1;
                    2'd1: if (cyc_data[3]) m_ovf = 1'b0;
                    2'd2: m_div = (cyc_data[15:0] == 16'd0) ? 1 : int'(cyc_data[15:0]);
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("txd", {31'd0, txd}, {31'd0, (m_active ? m_cur : 1'b1)});
            chk("tx_idle", {31'd0, tx_idle}, {31'd0, (m_q.size() == 0 && !m_active)});
            if (mem_re && (memaddr[29:2] == c_base[29:2]))
                chk("rdata", memdata, m_read(memaddr[1:0]));
            else if (tb_oe)
                chk("bus_hold", memdata, tb_val);
        end
    end

    // ---------------- bus driver ----------------
    // Called just after a rising edge; returns just after the edge ending the cycle
    task automatic bus(input bit re, input bit we, input logic [29:0] addr,
                       input logic [31:0] data, input bit drv, output logic [31:0] rdv);
        memaddr   = addr;
        mem_re    = re;
        cyc_store = we && !re;
        cyc_sel   = (addr[29:2] == c_base[29:2]);
        cyc_reg   = addr[1:0];
        cyc_data  = data;
        if (drv) begin
            tb_val = data;
            tb_oe  = 1'b1;
        end
        @(negedge clk);
        #1;
        rdv = memdata;
        if (we) begin
            if (!re) begin
                tb_val = data;
                tb_oe  = 1'b1;
            end
            #1 mem_we = 1'b1;
            #2 mem_we = 1'b0;
        end
        @(posedge clk);
        #1;
        tb_oe     = 1'b0;
        mem_re    = 1'b0;
        memaddr   = '0;
        cyc_store = 1'b0;
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        repeat (n) bus(1'b0, 1'b0, 30'h0, 32'h0, 1'b0, d);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] data);
        logic [31:0] d;
        bus(1'b0, 1'b1, c_base + 30'(r), data, 1'b0, d);
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        bus(1'b1, 1'b0, c_base + 30'(r), 32'h0, 1'b0, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        bit          a5 [10];
        int unsigned rsel;
        a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // 1. reset values
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_tx_idle", {31'd0, tx_idle}, 32'd1);
        rd(2'd1, v); chk("reset_status", v, 32'h0000_0002);
        rd(2'd2, v); chk("reset_div", v, 32'd868);

        // 2. single 0xA5 frame at DIV=4
        wr(2'd2, 32'd4);
        wr(2'd0, 32'hA5);
        chk("a5_before_pop", {31'd0, txd}, 32'd1);
        idle(1);
        chk("a5_start_edge", {31'd0, txd}, 32'd0);
        idle(1);
        chk("a5_busy_idle", {31'd0, tx_idle}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), {31'd0, txd}, {31'd0, a5[k]});
            idle(4);
        end
        chk("a5_done_idle", {31'd0, tx_idle}, 32'd1);

        // 3. overflow with 18 back-to-back stores at DIV=2
        wr(2'd2, 32'd2);
        for (int i = 0; i < 18; i++) wr(2'd0, 32'h10 + 32'(i));
        rd(2'd1, v); chk("ovf_status", v, 32'h0000_010D);
        wr(2'd1, 32'h8);
        rd(2'd1, v); chk("ovf_cleared", v, 32'h0000_0105);
        idle(350);

        // 4. push on the edge where STOP ends with one byte queued
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'hC3);
        idle(29);
        wr(2'd0, 32'h81);
        rd(2'd1, v); chk("pushpop_status", v, 32'h0000_0014);
        idle(70);

        // 5. DIV=0 clamps to 1; mid-byte DIV change
        wr(2'd2, 32'd0);
        rd(2'd2, v); chk("div0_reads_1", v, 32'd1);
        wr(2'd0, 32'h5A);
        idle(1);
        chk("div1_start", {31'd0, txd}, 32'd0);
        idle(9);
        chk("div1_stop_busy", {31'd0, tx_idle}, 32'd0);
        idle(1);
        chk("div1_frame10", {31'd0, tx_idle}, 32'd1);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h96);
        idle(10);
        wr(2'd2, 32'd2);
        idle(15);
        chk("divchg_still_busy", {31'd0, tx_idle}, 32'd0);
        idle(1);
        chk("divchg_done", {31'd0, tx_idle}, 32'd1);

        // Random bus traffic against the model
        wr(2'd2, 32'd3);
        for (int i = 0; i < 800; i++) begin
            rsel = $urandom_range(0, 99);
            if (rsel < 35)      wr(2'd0, $urandom);
            else if (rsel < 39) wr(2'd2, 32'($urandom_range(0, 4)));
            else if (rsel < 44) wr(2'd1, $urandom);
            else if (rsel < 64) rd(2'($urandom_range(0, 3)), v);
            else if (rsel < 69) bus(1'b1, 1'b0, 30'h1000 + 30'($urandom_range(0, 255)), $urandom, 1'b1, v);
            else if (rsel < 72) bus(1'b0, 1'b1, 30'h1000 + 30'($urandom_range(0, 255)), $urandom, 1'b0, v);
            else if (rsel < 75) wr(2'd3, $urandom);
            else if (rsel < 78) bus(1'b1, 1'b1, c_base, $urandom, 1'b0, v);
            else                idle(1);
        end
        idle(700);

        // 6. asynchronous reset mid-frame, then decode checks
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h00);
        wr(2'd0, 32'h55);
        idle(14);
        chk("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_txd", {31'd0, txd}, 32'd1);
        chk("async_rst_idle", {31'd0, tx_idle}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rd(2'd1, v); chk("post_rst_status", v, 32'h0000_0002);
        rd(2'd2, v); chk("post_rst_div", v, 32'd868);
        rd(2'd3, v); chk("reg3_read", v, 32'h0);
        bus(1'b1, 1'b0, 30'h0000_0123, 32'h5A5A_0000, 1'b1, v);
        chk("nonsel_no_drive", v, 32'h5A5A_0000);
        wr(2'd3, 32'hFF);
        rd(2'd1, v); chk("reg3_write_ignored", v, 32'h0000_0002);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
